// File: rtl/adder_arb.sv
// -----------------------------------------------------------------------------
// adder_arb
//
// Purpose:
//   Shares a single cl_adder among C_NUM_REQ requesters. An FSM
//   (IDLE -> CALC -> DONE) grants one requester and latches its operands.
//   It then gives the adder C_SETTLE cycles to settle, registers the
//   C_WIDTH+1 bit sum and pulses a one-cycle ack to the served requester.
//
//   Winner selection is round-robin by default: the search starts one
//   above the last served index and wraps around. When the macro
//   ADDER_ARB_FIXED_PRIORITY_EN is defined, selection is fixed priority
//   instead: the lowest index wins and no last-served state is kept.
//
// Parameters:
//   C_WIDTH    operand width in bits (4..64)
//   C_NUM_REQ  number of requesters (2..8)
//   C_SETTLE   adder settle cycles spent in CALC (1..15)
//
// Ports:
//   clk           single clock, rising edge
//   reset_n       asynchronous active-low reset
//   req           per-requester request level
//   a_in, b_in    packed operands, requester k at [k*C_WIDTH +: C_WIDTH]
//   ack           one-hot, one-cycle completion pulse
//   result        registered unsigned sum including carry-out
//   result_id     index of the requester that owns result
//   result_valid  high exactly while ack is high
//   busy          high whenever the FSM is not IDLE
//
// Configuration macro: ADDER_ARB_FIXED_PRIORITY_EN
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// cl_adder
//   Team adder: unsigned C_WIDTH + C_WIDTH -> C_WIDTH+1 bit sum built from
//   per-bit generate/propagate terms.
// Ports:
//   i_a, i_b  operands
//   o_sum     sum with carry-out in the MSB
// -----------------------------------------------------------------------------
module cl_adder #(
    parameter int C_WIDTH = 32
) (
    input  logic [C_WIDTH-1:0] i_a,
    input  logic [C_WIDTH-1:0] i_b,
    output logic [C_WIDTH:0]   o_sum
);

    logic [C_WIDTH-1:0] w_gen;
    logic [C_WIDTH-1:0] w_prop;

    assign w_gen  = i_a & i_b;
    assign w_prop = i_a ^ i_b;

    // The carry is a procedural local so the chain is not a combinational
    // loop through one module-level vector.
    always_comb begin
        logic v_carry;
        // NOTE: every output of a combinational block gets a default before
        // any conditional or partial assignment, so no latch is inferred.
        v_carry = 1'b0;
        o_sum   = '0;
        for (int i = 0; i < C_WIDTH; i++) begin
            o_sum[i] = w_prop[i] ^ v_carry;
            v_carry  = w_gen[i] | (w_prop[i] & v_carry);
        end
        o_sum[C_WIDTH] = v_carry;
    end

endmodule

// -----------------------------------------------------------------------------
// adder_arb top
// -----------------------------------------------------------------------------
module adder_arb #(
    parameter int C_WIDTH   = 32,
    parameter int C_NUM_REQ = 4,
    parameter int C_SETTLE  = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [C_NUM_REQ-1:0]           req,
    input  logic [C_NUM_REQ*C_WIDTH-1:0]   a_in,
    input  logic [C_NUM_REQ*C_WIDTH-1:0]   b_in,
    output logic [C_NUM_REQ-1:0]           ack,
    output logic [C_WIDTH:0]               result,
    output logic [$clog2(C_NUM_REQ)-1:0]   result_id,
    output logic                           result_valid,
    output logic                           busy
);

    localparam int             ID_W     = $clog2(C_NUM_REQ);
    localparam logic [3:0]     CNT_LOAD = 4'(C_SETTLE);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(C_NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // FSM and in-flight operation
    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [C_WIDTH-1:0]  r_a;
    logic [C_WIDTH-1:0]  r_b;
    logic [ID_W-1:0]     r_id;

    // Registered outputs
    logic [C_WIDTH:0]    r_result;
    logic [ID_W-1:0]     r_result_id;
    logic [C_NUM_REQ-1:0] r_ack;
    logic                r_valid;

    // Combinational helpers
    logic [ID_W-1:0]     w_win_id;
    logic [C_WIDTH:0]    w_sum;
    logic [C_NUM_REQ-1:0] w_id_onehot;

    // -------------------------------------------------------------------------
    // Winner selection
    // -------------------------------------------------------------------------
`ifdef ADDER_ARB_FIXED_PRIORITY_EN

    // Lowest set index wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_win_id = '0;
        for (int i = C_NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end

`else

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W + 1)'(C_NUM_REQ);

    logic [ID_W-1:0] r_last;

    // Round-robin: probe last+1, last+2, ... wrapping modulo C_NUM_REQ.
    // The offset C_NUM_REQ comes back to r_last itself, so a lone request
    // from the last-served requester is still granted.
    always_comb begin
        logic [ID_W:0] v_pos;
        logic          v_found;
        w_win_id = '0;
        v_pos    = '0;
        v_found  = 1'b0;
        for (int i = 1; i <= C_NUM_REQ; i++) begin
            v_pos = {1'b0, r_last} + (ID_W + 1)'(i);
            if (v_pos >= NUM_REQ_W) begin
                v_pos = v_pos - NUM_REQ_W;
            end
            if (!v_found && req[v_pos[ID_W-1:0]]) begin
                w_win_id = v_pos[ID_W-1:0];
                v_found  = 1'b1;
            end
        end
    end

`endif

    // -------------------------------------------------------------------------
    // Shared adder: sees only the latched operands, never the live inputs
    // -------------------------------------------------------------------------
    cl_adder #(
        .C_WIDTH (C_WIDTH)
    ) u_adder (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_sum (w_sum)
    );

    assign w_id_onehot = {{(C_NUM_REQ-1){1'b0}}, 1'b1} << r_id;

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: operand registers are reset as well, so the adder output
            // is never X even though it is only sampled in CALC.
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_result    <= '0;
            r_result_id <= '0;
            r_ack       <= '0;
            r_valid     <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIORITY_EN
            r_last      <= LAST_RST;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // branch reads pre-edge values, matching real flip-flops.
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_a     <= a_in[w_win_id*C_WIDTH +: C_WIDTH];
                        r_b     <= b_in[w_win_id*C_WIDTH +: C_WIDTH];
                        r_id    <= w_win_id;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    // The count holds the number of CALC cycles left,
                    // including the current one.
                    if (r_cnt == 4'd1) begin
                        r_result    <= w_sum;
                        r_result_id <= r_id;
                        r_ack       <= w_id_onehot;
                        r_valid     <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_DONE: begin
                    r_ack   <= '0;
                    r_valid <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIORITY_EN
                    r_last  <= r_result_id;
`endif
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_ack   <= '0;
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Unused when LAST_RST is not referenced in the fixed-priority build.
`ifdef ADDER_ARB_FIXED_PRIORITY_EN
    logic w_unused_last;
    assign w_unused_last = ^LAST_RST;
`endif

    assign ack          = r_ack;
    assign result       = r_result;
    assign result_id    = r_result_id;
    assign result_valid = r_valid;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adder_arb.sv
// -----------------------------------------------------------------------------
// tb_adder_arb
//   Directed bench for adder_arb. Instance u_dut_s2 uses C_SETTLE=2 and
//   instance u_dut_s1 uses C_SETTLE=1. Expected results are pushed to a
//   per-instance queue when a request is raised. They are popped and compared
//   when result_valid is seen.
// -----------------------------------------------------------------------------
module tb_adder_arb;

    localparam int W = 32;
    localparam int N = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    // Instance with C_SETTLE = 2
    logic [N-1:0]   req_a;
    logic [N*W-1:0] a_a, b_a;
    logic [N-1:0]   ack_a;
    logic [W:0]     res_a;
    logic [1:0]     rid_a;
    logic           rv_a, busy_a;

    // Instance with C_SETTLE = 1
    logic [N-1:0]   req_b;
    logic [N*W-1:0] a_b, b_b;
    logic [N-1:0]   ack_b;
    logic [W:0]     res_b;
    logic [1:0]     rid_b;
    logic           rv_b, busy_b;

    adder_arb #(.C_WIDTH(W), .C_NUM_REQ(N), .C_SETTLE(2)) u_dut_s2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req_a),
        .a_in         (a_a),
        .b_in         (b_a),
        .ack          (ack_a),
        .result       (res_a),
        .result_id    (rid_a),
        .result_valid (rv_a),
        .busy         (busy_a)
    );

    adder_arb #(.C_WIDTH(W), .C_NUM_REQ(N), .C_SETTLE(1)) u_dut_s1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req_b),
        .a_in         (a_b),
        .b_in         (b_b),
        .ack          (ack_b),
        .result       (res_b),
        .result_id    (rid_b),
        .result_valid (rv_b),
        .busy         (busy_b)
    );

    typedef struct {
        logic [1:0] id;
        logic [W:0] sum;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input bit which, input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        if (which) begin
            a_b[k*W +: W] = a;
            b_b[k*W +: W] = b;
        end else begin
            a_a[k*W +: W] = a;
            b_a[k*W +: W] = b;
        end
    endtask

    task automatic push(input bit which, input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.id  = 2'(id);
        e.sum = {1'b0, a} + {1'b0, b};
        if (which) q_b.push_back(e);
        else       q_a.push_back(e);
    endtask

    // Waits for result_valid and expects it exp_lat negedges after the call.
    // It then pops the scoreboard and checks result, result_id and ack.
    task automatic wait_done(input bit which, input int exp_lat, input string tag);
        int   n;
        bit   seen;
        bit   have;
        exp_t e;
        logic [N-1:0] exp_ack;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < exp_lat + 6) begin
            @(negedge clk);
            n++;
            seen = which ? rv_b : rv_a;
        end
        check({tag, "_latency"}, n, exp_lat);
        if (seen) begin
            have = which ? (q_b.size() != 0) : (q_a.size() != 0);
            check({tag, "_sb_nonempty"}, have, 1);
            if (have) begin
                if (which) e = q_b.pop_front();
                else       e = q_a.pop_front();
                exp_ack = 4'b0001 << e.id;
                check({tag, "_result"}, which ? res_b : res_a, e.sum);
                check({tag, "_id"},     which ? rid_b : rid_a, e.id);
                check({tag, "_ack"},    which ? ack_b : ack_a, exp_ack);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  fair_ids[5];
        int  thru_ids[4];
        bit  any_ack;

`ifdef ADDER_ARB_FIXED_PRIORITY_EN
        fair_ids = '{0, 0, 0, 0, 0};
        thru_ids = '{0, 0, 0, 0};
`else
        fair_ids = '{0, 1, 2, 3, 0};
        thru_ids = '{0, 1, 0, 1};
`endif

        req_a = '0; a_a = '0; b_a = '0;
        req_b = '0; a_b = '0; b_b = '0;
        reset_n = 1'b0;

        // Reset state, sampled while reset is held
        @(negedge clk);
        check("rst_busy",   busy_a, 0);
        check("rst_ack",    ack_a,  0);
        check("rst_valid",  rv_a,   0);
        check("rst_result", res_a,  0);
        check("rst_id",     rid_a,  0);
        check("rst_busy_s1", busy_b, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single request: 5 + 3, ack three cycles after the accept edge
        set_op(0, 0, 32'h0000_0005, 32'h0000_0003);
        push(0, 0, 32'h0000_0005, 32'h0000_0003);
        req_a = 4'b0001;
        wait_done(0, 3, "single");
        req_a[0] = 1'b0;
        @(negedge clk);
        check("single_idle_busy",  busy_a, 0);
        check("single_idle_ack",   ack_a,  0);
        check("single_idle_valid", rv_a,   0);
        check("single_hold_res",   res_a,  33'h0_0000_0008);
        check("single_hold_id",    rid_a,  0);

        // Carry-out from requester 2
        set_op(0, 2, 32'hFFFF_FFFF, 32'h0000_0001);
        push(0, 2, 32'hFFFF_FFFF, 32'h0000_0001);
        req_a = 4'b0100;
        wait_done(0, 3, "carry");
        req_a = 4'b0000;
        @(negedge clk);
        check("carry_hold_res", res_a, 33'h1_0000_0000);
        check("carry_hold_id",  rid_a, 2);

        // Fairness: a fresh reset, then all four requesting continuously
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            set_op(0, k, W'(1000 + k), W'(7 * k + 1));
        end
        for (int j = 0; j < 5; j++) begin
            push(0, fair_ids[j], W'(1000 + fair_ids[j]), W'(7 * fair_ids[j] + 1));
        end
        req_a = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_done(0, (j == 0) ? 3 : 4, "fair");
        end
        req_a = 4'b0000;
        @(negedge clk);

        // Operand stability: operand change and req drop after the accept edge
        set_op(0, 1, 32'd10, 32'd7);
        push(0, 1, 32'd10, 32'd7);
        req_a = 4'b0010;
        @(negedge clk);
        check("stable_busy", busy_a, 1);
        set_op(0, 1, 32'd99, 32'd7);
        req_a = 4'b0000;
        wait_done(0, 2, "stable");
        @(negedge clk);

        // Reset during CALC aborts with no ack
        set_op(0, 2, 32'd1, 32'd1);
        req_a = 4'b0100;
        @(negedge clk);
        check("abort_busy_before", busy_a, 1);
        reset_n = 1'b0;
        #1;
        check("abort_busy",   busy_a, 0);
        check("abort_ack",    ack_a,  0);
        check("abort_valid",  rv_a,   0);
        check("abort_result", res_a,  0);
        check("abort_id",     rid_a,  0);
        req_a = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
        any_ack = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rv_a || (ack_a != 4'b0000)) any_ack = 1'b1;
        end
        check("abort_no_ack", any_ack, 0);
        set_op(0, 1, 32'd20, 32'd22);
        push(0, 1, 32'd20, 32'd22);
        req_a = 4'b0010;
        wait_done(0, 3, "after_rst");
        req_a = 4'b0000;
        @(negedge clk);

        // Throughput with C_SETTLE = 1: acks three cycles apart
        set_op(1, 0, 32'd1, 32'd2);
        set_op(1, 1, 32'd3, 32'd4);
        for (int j = 0; j < 4; j++) begin
            push(1, thru_ids[j], (thru_ids[j] == 0) ? 32'd1 : 32'd3,
                                 (thru_ids[j] == 0) ? 32'd2 : 32'd4);
        end
        req_b = 4'b0011;
        for (int j = 0; j < 4; j++) begin
            wait_done(1, (j == 0) ? 2 : 3, "thru");
        end
        req_b = 4'b0000;
        @(negedge clk);
        check("thru_idle_busy", busy_b, 0);

        check("sb_a_drained", q_a.size(), 0);
        check("sb_b_drained", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_arb.md
ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 SHALL have parameter C_WIDTH, default 32, operand width in bits (legal 4..64).
REQ-002 SHALL have parameter C_NUM_REQ, default 4, number of requesters (legal 2..8).
REQ-003 SHALL have parameter C_SETTLE, default 2, adder settle cycles (legal 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  C_NUM_REQ  per-requester request level.
REQ-007 SHALL have port a_in  input  C_NUM_REQ*C_WIDTH  operand A; requester k uses slice [k*C_WIDTH +: C_WIDTH].
REQ-008 SHALL have port b_in  input  C_NUM_REQ*C_WIDTH  operand B; same slicing.
REQ-009 SHALL have port ack  output  C_NUM_REQ  one-hot, one-cycle completion pulse to the served requester.
REQ-010 SHALL have port result  output  C_WIDTH+1  registered sum including carry-out.
REQ-011 SHALL have port result_id  output  clog2(C_NUM_REQ)  index of the requester that owns result.
REQ-012 SHALL have port result_valid  output  1  high for exactly the cycle ack is high.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 SHALL share one instance of the team's cl_adder (C_WIDTH) among all requesters; no other adder.
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 In IDLE with req==0, SHALL remain in IDLE.
REQ-017 In IDLE with req!=0, SHALL select a winner, latch its a/b slices and index, load the settle counter with C_SETTLE, and move to CALC at that edge.
REQ-018 Winner selection SHALL be round-robin: first set bit searching upward from (last_served+1), wrapping from C_NUM_REQ-1 to 0.
REQ-019 CALC SHALL last exactly C_SETTLE cycles; the adder sees only latched operands; on the last CALC edge, result and result_id SHALL be registered and the state SHALL go to DONE.
REQ-020 DONE SHALL last one cycle with ack[result_id]=1 and result_valid=1, update last_served to result_id, and return to IDLE.
REQ-021 Accept-edge-to-ack latency SHALL be C_SETTLE+1 cycles; back-to-back throughput SHALL be one operation per C_SETTLE+2 cycles.
REQ-022 Requesters SHALL hold req and operands until they sample ack, then drop req; the IDLE following DONE SHALL therefore not re-grant the same completed request.
REQ-023 Changes to req, a_in or b_in during CALC/DONE SHALL NOT affect the operation in flight; a dropped req SHALL still receive its ack.
REQ-024 result and result_id SHALL hold their values outside DONE until the next DONE.
REQ-025 Arithmetic SHALL be unsigned; result = a + b, full C_WIDTH+1 bits, no truncation or saturation.

Reset
REQ-026 reset_n low SHALL immediately force state=IDLE, ack=0, result_valid=0, busy=0, result=0, result_id=0, counter=0, last_served=C_NUM_REQ-1 (so requester 0 wins first).
REQ-027 Reset asserted in CALC or DONE SHALL abort the operation with no ack issued.
REQ-028 After reset_n deasserts, the first arbitration SHALL occur on the first rising edge with req!=0.

Configuration
REQ-029 With macro ADDER_ARB_FIXED_PRIORITY_EN defined, winner selection SHALL be fixed priority (lowest index wins) and last_served SHALL be unused.
REQ-030 Without ADDER_ARB_FIXED_PRIORITY_EN, winner selection SHALL be round-robin per REQ-018; all other behaviour SHALL be identical.

Verification
REQ-031 Single request: after reset, req=4'b0001, a0=32'h0000_0005, b0=32'h0000_0003, C_SETTLE=2 -> ack=4'b0001 three cycles after accept edge, result=33'h0_0000_0008, result_id=0.
REQ-032 Carry-out: a2=32'hFFFF_FFFF, b2=32'h0000_0001 -> result=33'h1_0000_0000, result_id=2.
REQ-033 Round-robin fairness: req=4'b1111 held continuously (each requester re-raises after ack) -> service order 0,1,2,3,0; with ADDER_ARB_FIXED_PRIORITY_EN -> 0,0,0.
REQ-034 Operand stability: a1 changed from 10 to 99 in the cycle after accept -> result=10+b1; req1 dropped during CALC -> ack[1] still pulses.
REQ-035 Reset mid-operation: reset_n low for one cycle during CALC -> busy=0 immediately, no ack; next req=4'b0010 served as requester 1.
REQ-036 Throughput: C_SETTLE=1, req=4'b0011 held -> acks exactly 3 cycles apart, alternating ack=0001/0010.
